// File: rtl/imem_loader_ctrl.sv
// Instruction-memory loader: holds the core in reset, packs a little-endian byte stream
// into words, writes them from word 0, then releases the core. Option: IMEM_LOAD_CHECKSUM_EN.
module imem_loader_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   num_words_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       cpu_pc_i,
  output logic [ADDR_W-1:0] mem_raddr_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              pc_fault_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam logic [2:0] S_CHECK   = 3'd4;
`endif
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [2:0]      state_q, state_d;
  // one bit wider than the address so the post-increment after word DEPTH-1 cannot wrap
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic [ADDR_W:0] num_q, num_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [31:0]     buf_q, buf_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            pc_fault_q, pc_fault_d;
  logic            start_ok, last_word, pc_bad;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]     sum_q, sum_d;
  logic            chk_q, chk_d;
`endif

  assign start_ok  = (num_words_i != '0) && (num_words_i <= DEPTH_W);
  assign last_word = (wcnt_q == num_q - 1'b1);
  assign pc_bad    = (|cpu_pc_i[31:ADDR_W+2]) || (|cpu_pc_i[1:0]);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    num_d   = num_q;
    bcnt_d  = bcnt_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum_d   = sum_q;
    chk_d   = chk_q;
`endif
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start_i) begin
          if (start_ok) begin
            num_d   = num_words_i;
            wcnt_d  = '0;
            bcnt_d  = '0;
            state_d = S_COLLECT;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_d   = '0;
            chk_d   = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (byte_valid_i) begin
          buf_d[{bcnt_q, 3'b000} +: 8] = byte_data_i;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            state_d = chk_q ? S_CHECK : S_WRITE;
`else
            state_d = S_WRITE;
`endif
          end
        end
      end
      S_WRITE: begin
        wcnt_d = wcnt_q + 1'b1;
        bcnt_d = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        sum_d = sum_q + buf_q;
        if (last_word) begin
          chk_d   = 1'b1;
          state_d = S_COLLECT;
        end else begin
          state_d = S_COLLECT;
        end
`else
        if (last_word) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else begin
          state_d = S_COLLECT;
        end
`endif
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHECK: begin
        chk_d = 1'b0;
        if (buf_q == sum_q) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // evaluated against the next state so the flag drops as soon as RUN is left
    pc_fault_d = (state_d == S_RUN) && pc_bad;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      num_q      <= '0;
      bcnt_q     <= '0;
      buf_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pc_fault_q <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q      <= '0;
      chk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      num_q      <= num_d;
      bcnt_q     <= bcnt_d;
      buf_q      <= buf_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pc_fault_q <= pc_fault_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q      <= sum_d;
      chk_q      <= chk_d;
`endif
    end
  end

  assign byte_ready_o = (state_q == S_COLLECT);
  // a reset landing on a WRITE cycle must not commit the word
  assign mem_we_o     = (state_q == S_WRITE) && !reset_i;
  assign mem_waddr_o  = wcnt_q[ADDR_W-1:0];
  assign mem_wdata_o  = buf_q;
  assign mem_raddr_o  = cpu_pc_i[ADDR_W+1:2];
  assign cpu_reset_o  = (state_q != S_RUN);
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign busy_o       = (state_q == S_COLLECT) || (state_q == S_WRITE) || (state_q == S_CHECK);
`else
  assign busy_o       = (state_q == S_COLLECT) || (state_q == S_WRITE);
`endif
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign pc_fault_o   = pc_fault_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed bench for imem_loader_ctrl: expected writes are queued at stimulus time
// and retired by a monitor whenever the DUT pulses mem_we.
module tb_imem_loader_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  num_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, cpu_reset, busy, done, err, pc_fault;
  logic [5:0]  mem_waddr, mem_raddr;
  logic [31:0] mem_wdata;
  logic [31:0] cpu_pc = '0;

  int checks = 0, errors = 0, we_cnt = 0, done_cnt = 0;
  logic [37:0] exp_q[$];
  logic [7:0]  bq[$];

  imem_loader_ctrl dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .num_words_i(num_words),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .mem_we_o(mem_we), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
    .cpu_pc_i(cpu_pc), .mem_raddr_o(mem_raddr), .cpu_reset_o(cpu_reset),
    .busy_o(busy), .done_o(done), .err_o(err), .pc_fault_o(pc_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard retire + done-pulse tracking, sampled mid-cycle
  always @(negedge clk) begin
    logic [37:0] e;
    if (mem_we === 1'b1) begin
      we_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write got=%h exp=none", {mem_waddr, mem_wdata});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write", {26'd0, mem_waddr, mem_wdata}, {26'd0, e});
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("cpu_reset_at_done", cpu_reset, 1'b0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) chk("byte_ready_timeout", 0, 1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic load(input int n, input int gap);
    int w0, d0, t;
    w0 = we_cnt;
    d0 = done_cnt;
    num_words = 7'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("cpu_reset_in_load", cpu_reset, 1'b1);
    chk("pc_fault_clear_in_load", pc_fault, 1'b0);
    while (bq.size() != 0) send_byte(bq.pop_front(), gap);
    t = 0;
    while (done_cnt == d0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("write_count", we_cnt - w0, n);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("cpu_reset_run", cpu_reset, 1'b0);
    chk("busy_run", busy, 1'b0);
  endtask

  task automatic bad_start(input logic [6:0] n);
    int w0;
    w0 = we_cnt;
    num_words = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", err, 1'b1);
    chk("busy_after_bad", busy, 1'b0);
    chk("ready_after_bad", byte_ready, 1'b0);
    @(posedge clk); #1;
    chk("err_one_cycle", err, 1'b0);
    chk("cpu_reset_idle", cpu_reset, 1'b1);
    chk("no_write_bad", we_cnt - w0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_byte_ready", byte_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_pc_fault", pc_fault, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    bad_start(7'd0);
    bad_start(7'd65);

    // back-to-back two-word load
    exp_q.push_back({6'd0, 32'h12345678});
    exp_q.push_back({6'd1, 32'hDEADBEEF});
    bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(2, 0);

    // same load, started from RUN, with 3 idle cycles between bytes
    exp_q.push_back({6'd0, 32'h12345678});
    exp_q.push_back({6'd1, 32'hDEADBEEF});
    bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(2, 3);

    // PC mapping and fault flag in RUN
    cpu_pc = 32'h0000_0008;
    #1 chk("raddr_8", mem_raddr, 6'd2);
    @(posedge clk); #1;
    chk("pc_fault_8", pc_fault, 1'b0);
    cpu_pc = 32'h0000_0104;
    #1 chk("raddr_104", mem_raddr, 6'd1);
    @(posedge clk); #1;
    chk("pc_fault_104", pc_fault, 1'b1);
    cpu_pc = 32'h0000_0002;
    @(posedge clk); #1;
    chk("pc_fault_misaligned", pc_fault, 1'b1);
    cpu_pc = 32'h0;

    // reset mid-word, then a fresh single-word load
    num_words = 7'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_cpu_reset", cpu_reset, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", byte_ready, 1'b0);
    exp_q.push_back({6'd0, 32'hE3A00001});
    bq = '{8'h01, 8'h00, 8'hA0, 8'hE3};
    load(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_loader_ctrl.md
Name: imem_loader_ctrl

Overview:
- Controller that owns the write side of the processor's 64-word instruction memory and the processor's run/hold state.
- Sits between a byte-stream program source (UART/debug link) and the pipelined ARM core.
- Holds the core in reset, assembles incoming bytes into 32-bit words, and writes them sequentially from word 0. It then releases the core and maps the fetch PC onto the word read address.

Parameters:
- DEPTH, 64, number of 32-bit words in the instruction memory.
- ADDR_W, 6, word-address width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a program load; sampled only in IDLE or RUN.
- num_words  in  ADDR_W+1  program length in words; sampled with start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  program byte stream, little-endian within each word.
- byte_ready  out  1  controller accepts a byte this cycle.
- mem_we  out  1  instruction-memory write enable.
- mem_waddr  out  ADDR_W  write word address.
- mem_wdata  out  32  assembled write word.
- cpu_pc  in  32  fetch byte address from the core.
- mem_raddr  out  ADDR_W  read word address, equal to cpu_pc[ADDR_W+1:2], combinational.
- cpu_reset  out  1  holds the core in reset; high whenever state != RUN.
- busy  out  1  high in COLLECT or WRITE.
- done  out  1  one-cycle pulse on the first RUN cycle after a successful load.
- err  out  1  one-cycle pulse on a rejected start.
- pc_fault  out  1  registered; high in RUN when cpu_pc[31:ADDR_W+2] != 0 or cpu_pc[1:0] != 0.

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- States are IDLE, COLLECT, WRITE and RUN. Outputs are Moore-decoded from state.
  - byte_ready = (state == COLLECT).
  - mem_we = (state == WRITE).
- Reset values: state = IDLE, word counter = 0, byte counter = 0, word buffer = 0, done = 0, err = 0, pc_fault = 0, cpu_reset = 1, busy = 0.
- IDLE or RUN with start = 1:
  - If 1 <= num_words <= DEPTH: latch num_words, clear both counters, go to COLLECT. cpu_reset goes to 1 in the next cycle.
  - Otherwise (num_words == 0 or num_words > DEPTH): err pulses high in the next cycle and the state is unchanged.
- COLLECT: on byte_valid & byte_ready, write byte k (k = byte counter 0..3) into buffer bits [8k+7:8k] and increment the byte counter. Accepting the 4th byte moves to WRITE. byte_valid low means hold with no change.
- WRITE (exactly one cycle):
  - mem_we = 1, mem_waddr = word counter, mem_wdata = buffer.
  - Next cycle, increment the word counter and clear the byte counter.
  - If this was the last word (word counter == latched num_words − 1), go to RUN and pulse done. Otherwise return to COLLECT.
- Latency: the WRITE cycle immediately follows the cycle the 4th byte is accepted. Minimum load time is 5·N cycles for N words.
- RUN: cpu_reset = 0. pc_fault is registered each cycle from cpu_pc and cleared outside RUN.
- start in COLLECT/WRITE is ignored and causes no err.
- reset during a load returns to IDLE and discards the partial word. Words already written stay in memory. No write occurs in the reset cycle.
- mem_waddr never exceeds DEPTH−1; the word counter does not wrap within a load.

Optional Feature:
- Macro IMEM_LOAD_CHECKSUM_EN.
- Defined:
  - After the last program word, one extra 4-byte checksum word is collected (COLLECT → new state CHECK) and is not written to memory.
  - The running 32-bit modulo-2^32 sum of all written words is compared with it.
  - Match: RUN plus done pulse.
  - Mismatch: err pulse, go to IDLE (core held in reset).
- Not defined: the CHECK state and the sum register are absent, and the last WRITE goes directly to RUN.

Test Plan:
- Assert reset for 2 cycles → cpu_reset=1, mem_we=0, byte_ready=0, busy=0, done=0, err=0.
- start with num_words=2, bytes 78 56 34 12 EF BE AD DE back-to-back → write 0x12345678 at address 0, then 0xDEADBEEF at address 1. done pulses once, cpu_reset falls in the same cycle, and there are exactly 2 mem_we cycles.
- Same load with byte_valid low for 3 cycles between every byte → identical writes, no extra mem_we, done after the final WRITE.
- start with num_words=0, then with num_words=65, from IDLE → err pulses one cycle each, state stays IDLE, no writes.
- reset after 2 bytes of a word, then load num_words=1 with bytes 01 00 A0 E3 → single write of 0xE3A00001 at address 0, followed by RUN.
- In RUN: cpu_pc=0x00000008 → mem_raddr=2, pc_fault=0. cpu_pc=0x00000104 → mem_raddr=1, pc_fault=1 on the next cycle.
